// File: rtl/gelu_pkg.sv
// Shared constants and types for the GELU vector sequencer slice.
// Q6.10 fixed-point format and LUT range used by the GELU unit.
package gelu_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 10;

  localparam logic signed [15:0] LUT_MIN  = -16'sh1000;
  localparam logic signed [15:0] LUT_STEP = 16'sd128;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/gelu_vec_sequencer_if.sv
// Bus bundle between the sequencer and the source SRAM,
// the GELU unit and the destination SRAM write port.
interface gelu_vec_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 8
);

  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] gelu_x;
  logic                  gelu_valid_in;
  logic [DATA_WIDTH-1:0] gelu_y;
  logic                  gelu_valid_out;
  logic                  gelu_oor;
  logic                  wr_en;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output gelu_x, gelu_valid_in,
    input  gelu_y, gelu_valid_out, gelu_oor,
    output wr_en, wr_addr, wr_data,
    input  wr_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  gelu_x, gelu_valid_in,
    output gelu_y, gelu_valid_out, gelu_oor,
    input  wr_en, wr_addr, wr_data,
    output wr_ready
  );

endinterface

// File: rtl/gelu_seq_fifo.sv
// Result FIFO between the non-stallable GELU output and the write port.
// Head is visible combinationally; count drives the issue credits.
module gelu_seq_fifo #(
  parameter  int DATA_WIDTH = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rp;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rp];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/gelu_vec_sequencer.sv
// Streams one vector src SRAM -> GELU unit -> FIFO -> dst SRAM.
// GELU_SEQ_OOR_CNT_EN adds the oor_count output.
module gelu_vec_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 8,
  parameter int LEN_W      = 9,
  parameter int GELU_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  gelu_vec_sequencer_if.master bus
`ifdef GELU_SEQ_OOR_CNT_EN
  ,
  output logic [LEN_W-1:0]  oor_count
`endif
);

  import gelu_pkg::*;

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int IW  = $clog2(GELU_LAT + 2);

  seq_state_t            state;
  seq_state_t            state_nx;
  logic [ADDR_W-1:0]     src_q;
  logic [ADDR_W-1:0]     dst_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      issued;
  logic [LEN_W-1:0]      written;
  logic [IW-1:0]         inflight;
  logic                  gvi;
  logic                  run;
  logic                  go;
  logic                  push;
  logic                  accept;
  logic                  last_wr;
  logic                  can_issue;
  logic [DATA_WIDTH-1:0] head;
  logic [FCW-1:0]        fcount;
  logic                  ffull;
  logic                  fempty;

  assign run       = (state == RUN);
  assign go        = (state == IDLE) & start;
  assign push      = run & bus.gelu_valid_out;
  assign can_issue = (int'(fcount) + int'(inflight)) < FIFO_DEPTH;
  assign accept    = run & bus.wr_en & bus.wr_ready;
  assign last_wr   = accept & ((written + LEN_W'(1)) == len_q);

  assign bus.rd_en         = run & (issued < len_q) & can_issue;
  assign bus.rd_addr       = src_q + ADDR_W'(issued);
  assign bus.gelu_valid_in = gvi;
  assign bus.gelu_x        = gvi ? bus.rd_data : '0;
  assign bus.wr_en         = ~fempty;
  assign bus.wr_data       = fempty ? '0 : head;
  assign bus.wr_addr       = dst_q + ADDR_W'(written);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  gelu_seq_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.gelu_y),
    .pop       (accept),
    .pop_data  (head),
    .count     (fcount),
    .full      (ffull),
    .empty     (fempty)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state: finish on the last accepted write
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (length == '0) ? DONE : RUN;
      RUN:  if (last_wr) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // vector context, progress counters and credit tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      issued   <= '0;
      written  <= '0;
      inflight <= '0;
      gvi      <= 1'b0;
    end else begin
      gvi <= bus.rd_en;
      if (go) begin
        src_q    <= src_base;
        dst_q    <= dst_base;
        len_q    <= length;
        issued   <= '0;
        written  <= '0;
        inflight <= '0;
      end else begin
        if (bus.rd_en) issued <= issued + 1'b1;
        if (accept) written <= written + 1'b1;
        inflight <= inflight + IW'(bus.rd_en) - IW'(push);
      end
    end
  end

`ifdef GELU_SEQ_OOR_CNT_EN
  // saturating count of out-of-range results in the current vector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oor_count <= '0;
    end else if (go) begin
      oor_count <= '0;
    end else if (push & bus.gelu_oor & ~&oor_count) begin
      oor_count <= oor_count + 1'b1;
    end
  end
`endif

endmodule
